demux_1_n_stream: RTL and testbench
===================================

Name: demux_1_n_stream

Overview:
- Parametrised, registered 1:N demultiplexer with valid/ready streaming handshake. It succeeds the combinational 1:2 demux.
- Steers each accepted input beat to one of NUM_CHANNELS output channels. The target channel comes from an explicit select or from an internal round-robin pointer.
- Sits between a single producer and N consumer streams in the data-selector library.

Parameters:
- DATA_WIDTH, 8, width of each data beat.
- NUM_CHANNELS, 4, number of output channels (>=2; need not be a power of 2).
- SEL_WIDTH, derived localparam = $clog2(NUM_CHANNELS), width of select and pointer.

Ports:
- Clock_In  input  1  single clock; all logic on rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Enable_In  input  1  1 = accept new beats; 0 = stop accepting (a held beat still drains).
- Mode_In  input  1  0 = explicit select; 1 = round-robin.
- Data_In  input  DATA_WIDTH  input beat.
- Select_In  input  SEL_WIDTH  target channel in explicit mode; ignored in round-robin mode.
- Valid_In  input  1  input beat valid.
- Ready_Out  output  1  block can accept a beat this cycle.
- DEMUX_Data_Out  output  NUM_CHANNELS*DATA_WIDTH  flattened; channel k at [k*DATA_WIDTH +: DATA_WIDTH].
- DEMUX_Valid_Out  output  NUM_CHANNELS  per-channel valid; at most one bit set.
- DEMUX_Ready_In  input  NUM_CHANNELS  per-channel consumer ready.
- Current_Channel_Out  output  SEL_WIDTH  round-robin pointer value.
- Select_Error_Out  output  1  one-cycle pulse when a beat is dropped for out-of-range select.

Behaviour:
- Reset (sync, active-high): all outputs 0, held-beat flag cleared, pointer = 0. Any in-flight held beat is discarded. Reset overrides every other event in the same cycle.
- Storage: a single output register stage holding one beat, its channel index, and a held flag.
- Ready_Out = Enable_In && (!held || DEMUX_Ready_In[held_ch]). Combinational from state and DEMUX_Ready_In only; never depends on Valid_In.
- Accept: Valid_In && Ready_Out at the clock edge.
- Target channel: Select_In when Mode_In = 0; pointer when Mode_In = 1.
- Drain: held && DEMUX_Ready_In[held_ch] at the clock edge.
- Simultaneous drain and accept: the new beat replaces the held beat in the same edge. Full throughput is 1 beat/cycle when the consumer is always ready.
- Latency: a beat accepted at edge t appears on DEMUX_Valid_Out/DEMUX_Data_Out after edge t, visible in cycle t+1.
- Output data: channel k slice = held data when held && held_ch == k, else all zeros.
- DEMUX_Valid_Out[k] = held && held_ch == k.
- Held data and channel remain stable while valid and not ready (no change under backpressure).
- Round-robin pointer:
  - Increments on every accept in Mode_In = 1.
  - Wraps from NUM_CHANNELS-1 to 0.
  - Unchanged in Mode_In = 0.
  - Not reset by a mode change; a mode change applies from the next accept.
- Out-of-range select (explicit mode, Select_In >= NUM_CHANNELS, possible only when NUM_CHANNELS is not a power of 2):
  - The beat is accepted (handshake completes) and dropped.
  - Select_Error_Out pulses 1 for the cycle after the accept edge.
  - The held beat is unaffected unless it drained in that same edge.
- Enable_In low: Ready_Out = 0. The held beat still drains normally, and the pointer holds its value.

Optional Feature:
- Macro DEMUX_1_N_CHANNEL_COUNT_EN.
- When defined:
  - Adds output port Channel_Count_Out, width NUM_CHANNELS*16; channel k at [k*16 +: 16].
  - Each counter increments by 1 on each drain of that channel and wraps 0xFFFF to 0x0000.
  - Counters reset to 0.
  - Dropped out-of-range beats are not counted.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: Reset_In = 1 for 2 cycles with Valid_In = 1 -> all outputs 0, Current_Channel_Out = 0; Ready_Out = 1 after reset if Enable_In = 1.
- Explicit steering: Mode_In = 0, DEMUX_Ready_In = 4'b1111, send Data_In = 8'hA5 with Select_In = 2 -> next cycle DEMUX_Valid_Out = 4'b0100, channel 2 data = 8'hA5, other slices = 8'h00.
- Backpressure: held beat 8'h3C on channel 1 with DEMUX_Ready_In[1] = 0 for 5 cycles -> Ready_Out = 0, data and valid stable. Raise ready -> drains, Ready_Out = 1 in the same cycle.
- Round-robin: Mode_In = 1, 6 back-to-back beats 8'h10..8'h15, all ready -> channels 0,1,2,3,0,1 in order, 1 beat/cycle, Current_Channel_Out ends at 2.
- Disable mid-stream: Enable_In = 0 while a beat is held and its channel is ready -> held beat drains, no new accept, pointer unchanged.
- Out-of-range select: NUM_CHANNELS = 3, Select_In = 3, Valid_In = 1 -> beat accepted, Select_Error_Out pulses 1 for one cycle, DEMUX_Valid_Out = 0. With the counter macro defined: counts unchanged, and 3 drains on channel 0 give Channel_Count_Out[15:0] = 3.

Source files
------------

// File: rtl/demux_1_n_stream.sv
// Purpose: registered 1:N stream demultiplexer; beats are steered by Select_In or by a round-robin pointer.
// Latency: one cycle; a beat accepted at edge t is presented on its channel during cycle t+1.
// Backpressure: one-beat output register; Ready_Out falls while the held beat's consumer is not ready.
//
// Ports: Clock_In/Reset_In (sync, active-high), Enable_In gates new accepts, Mode_In (0 select, 1 round-robin),
//        Data_In/Select_In/Valid_In/Ready_Out input stream, DEMUX_* per-channel output streams (flattened),
//        Current_Channel_Out round-robin pointer, Select_Error_Out one-cycle drop pulse.
// Optional: define DEMUX_1_N_CHANNEL_COUNT_EN to add Channel_Count_Out, 16-bit wrapping drain counters per channel.
module demux_1_n_stream #(
    parameter  int DATA_WIDTH   = 8,
    parameter  int NUM_CHANNELS = 4,
    localparam int SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
    input  logic                               Clock_In,
    input  logic                               Reset_In,
    input  logic                               Enable_In,
    input  logic                               Mode_In,
    input  logic [DATA_WIDTH-1:0]              Data_In,
    input  logic [SEL_WIDTH-1:0]               Select_In,
    input  logic                               Valid_In,
    output logic                               Ready_Out,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] DEMUX_Data_Out,
    output logic [NUM_CHANNELS-1:0]            DEMUX_Valid_Out,
    input  logic [NUM_CHANNELS-1:0]            DEMUX_Ready_In,
    output logic [SEL_WIDTH-1:0]               Current_Channel_Out,
`ifdef DEMUX_1_N_CHANNEL_COUNT_EN
    output logic [NUM_CHANNELS*16-1:0]         Channel_Count_Out,
`endif
    output logic                               Select_Error_Out
);

    // One extra bit so the channel count itself is representable for the range check.
    localparam logic [SEL_WIDTH:0]   NUM_CH_EXT = (SEL_WIDTH+1)'(NUM_CHANNELS);
    localparam logic [SEL_WIDTH-1:0] LAST_CH    = SEL_WIDTH'(NUM_CHANNELS - 1);

    logic                  held_q, held_d;
    logic [SEL_WIDTH-1:0]  held_ch_q, held_ch_d;
    logic [DATA_WIDTH-1:0] held_dat_q, held_dat_d;
    logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
    logic                  sel_err_q, sel_err_d;

    logic                  held_ch_rdy;
    logic                  drain;
    logic                  accept;
    logic [SEL_WIDTH-1:0]  tgt_ch;
    logic                  tgt_in_range;

    // held_ch_q only ever holds an in-range channel, so this index is always valid.
    assign held_ch_rdy  = DEMUX_Ready_In[held_ch_q];
    assign drain        = held_q && held_ch_rdy;
    // Ready looks only at state and consumer ready, never at Valid_In.
    assign Ready_Out    = Enable_In && (!held_q || held_ch_rdy);
    assign accept       = Valid_In && Ready_Out;
    assign tgt_ch       = Mode_In ? ptr_q : Select_In;
    assign tgt_in_range = ({1'b0, tgt_ch} < NUM_CH_EXT);

    always_comb begin
        held_d     = held_q;
        held_ch_d  = held_ch_q;
        held_dat_d = held_dat_q;
        ptr_d      = ptr_q;
        sel_err_d  = 1'b0;

        if (drain) begin
            held_d = 1'b0;
        end

        // An accept in the same edge as a drain simply overwrites the register.
        if (accept) begin
            if (tgt_in_range) begin
                held_d     = 1'b1;
                held_ch_d  = tgt_ch;
                held_dat_d = Data_In;
            end else begin
                // Out-of-range beat completes its handshake but is discarded.
                sel_err_d = 1'b1;
            end
            if (Mode_In) begin
                ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            held_q     <= 1'b0;
            held_ch_q  <= '0;
            held_dat_q <= '0;
            ptr_q      <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            held_q     <= held_d;
            held_ch_q  <= held_ch_d;
            held_dat_q <= held_dat_d;
            ptr_q      <= ptr_d;
            sel_err_q  <= sel_err_d;
        end
    end

    always_comb begin
        DEMUX_Data_Out  = '0;
        DEMUX_Valid_Out = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (held_q && (held_ch_q == SEL_WIDTH'(k))) begin
                DEMUX_Valid_Out[k]                         = 1'b1;
                DEMUX_Data_Out[k*DATA_WIDTH +: DATA_WIDTH] = held_dat_q;
            end
        end
    end

    assign Current_Channel_Out = ptr_q;
    assign Select_Error_Out    = sel_err_q;

`ifdef DEMUX_1_N_CHANNEL_COUNT_EN
    logic [15:0] cnt_q [NUM_CHANNELS];
    logic [15:0] cnt_d [NUM_CHANNELS];

    // Only real drains count; dropped beats never reach the register.
    always_comb begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (drain && (held_ch_q == SEL_WIDTH'(k))) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
    end

    always_ff @(posedge Clock_In) begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (Reset_In) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        Channel_Count_Out = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            Channel_Count_Out[k*16 +: 16] = cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Purpose: randomized and directed scoreboard bench for demux_1_n_stream with a 3-channel build.
// Latency: the model expects each accepted beat visible from the cycle after its accept edge.
// Backpressure: beats leave in acceptance order, one at a time, held until their channel is ready.
module tb_demux_1_n_stream;

    localparam int DW  = 8;
    localparam int NCH = 3;
    localparam int SW  = 2;

    logic              clk = 1'b0;
    logic              Reset_In;
    logic              Enable_In;
    logic              Mode_In;
    logic [DW-1:0]     Data_In;
    logic [SW-1:0]     Select_In;
    logic              Valid_In;
    logic              Ready_Out;
    logic [NCH*DW-1:0] DEMUX_Data_Out;
    logic [NCH-1:0]    DEMUX_Valid_Out;
    logic [NCH-1:0]    DEMUX_Ready_In;
    logic [SW-1:0]     Current_Channel_Out;
    logic              Select_Error_Out;
`ifdef DEMUX_1_N_CHANNEL_COUNT_EN
    logic [NCH*16-1:0] cnt_out;
    logic [15:0]       cnt_m [NCH];
`endif

    always #5 clk = ~clk;

    demux_1_n_stream #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH)) dut (
        .Clock_In            (clk),
        .Reset_In            (Reset_In),
        .Enable_In           (Enable_In),
        .Mode_In             (Mode_In),
        .Data_In             (Data_In),
        .Select_In           (Select_In),
        .Valid_In            (Valid_In),
        .Ready_Out           (Ready_Out),
        .DEMUX_Data_Out      (DEMUX_Data_Out),
        .DEMUX_Valid_Out     (DEMUX_Valid_Out),
        .DEMUX_Ready_In      (DEMUX_Ready_In),
        .Current_Channel_Out (Current_Channel_Out),
`ifdef DEMUX_1_N_CHANNEL_COUNT_EN
        .Channel_Count_Out   (cnt_out),
`endif
        .Select_Error_Out    (Select_Error_Out)
    );

    typedef struct {
        int            ch;
        logic [DW-1:0] dat;
        int            acc;
    } beat_t;

    beat_t exp_q [$];   // accepted in-range beats, oldest first
    int    errq  [$];   // accept cycles of dropped beats
    int    cyc    = 0;
    int    rr_ptr = 0;
    int    n_cmp  = 0;
    int    n_bad  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // The beat on the output is the oldest accepted beat whose accept edge has passed.
    function automatic bit model_held(output int ch);
        ch = 0;
        if (exp_q.size() > 0 && exp_q[0].acc < cyc) begin
            ch = exp_q[0].ch;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input logic en, input logic mode, input logic [SW-1:0] sel,
                        input logic [DW-1:0] dat, input logic vld, input logic [NCH-1:0] rdy,
                        input logic rst);
        bit    hv;
        int    hch;
        int    tgt;
        logic  exp_rdy;
        beat_t b;
        @(negedge clk);
        Reset_In       = rst;
        Enable_In      = en;
        Mode_In        = mode;
        Select_In      = sel;
        Data_In        = dat;
        Valid_In       = vld;
        DEMUX_Ready_In = rdy;
        #1;
        if (rst) begin
            exp_q.delete();
            errq.delete();
            rr_ptr = 0;
        end else begin
            hv      = model_held(hch);
            exp_rdy = en && (!hv || rdy[hch]);
            check("ready_out", 64'(Ready_Out), 64'(exp_rdy));
            check("current_channel", 64'(Current_Channel_Out), 64'(rr_ptr));
            if (vld && exp_rdy) begin
                tgt = mode ? rr_ptr : int'(sel);
                if (tgt < NCH) begin
                    b.ch  = tgt;
                    b.dat = dat;
                    b.acc = cyc;
                    exp_q.push_back(b);
                end else begin
                    errq.push_back(cyc);
                end
                if (mode) rr_ptr = (rr_ptr + 1) % NCH;
            end
        end
    endtask

    // Monitor: compares what the DUT presents this cycle against the scoreboard, then retires drains.
    initial begin
        bit              hv;
        int              hch;
        logic [NCH-1:0]  exp_v;
        logic [NCH*DW-1:0] exp_d;
        logic            exp_err;
        forever begin
            @(negedge clk);
            #2;
            if (Reset_In === 1'b1) begin
`ifdef DEMUX_1_N_CHANNEL_COUNT_EN
                for (int k = 0; k < NCH; k++) cnt_m[k] = '0;
`endif
            end else begin
                hv    = model_held(hch);
                exp_v = '0;
                exp_d = '0;
                if (hv) begin
                    exp_v[hch]           = 1'b1;
                    exp_d[hch*DW +: DW]  = exp_q[0].dat;
                end
                check("valid_out", 64'(DEMUX_Valid_Out), 64'(exp_v));
                check("data_out", 64'(DEMUX_Data_Out), 64'(exp_d));
                exp_err = (errq.size() > 0) && (errq[0] + 1 == cyc);
                check("select_error", 64'(Select_Error_Out), 64'(exp_err));
                if (exp_err) void'(errq.pop_front());
`ifdef DEMUX_1_N_CHANNEL_COUNT_EN
                for (int k = 0; k < NCH; k++)
                    check("channel_count", 64'(cnt_out[k*16 +: 16]), 64'(cnt_m[k]));
`endif
                if (hv && DEMUX_Ready_In[hch]) begin
                    void'(exp_q.pop_front());
`ifdef DEMUX_1_N_CHANNEL_COUNT_EN
                    cnt_m[hch] = cnt_m[hch] + 16'd1;
`endif
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        Reset_In       = 1'b1;
        Enable_In      = 1'b1;
        Mode_In        = 1'b0;
        Select_In      = '0;
        Data_In        = '0;
        Valid_In       = 1'b1;
        DEMUX_Ready_In = '1;

        // Reset held with a valid input present.
        repeat (2) step(1, 0, 0, 8'hFF, 1, 3'b111, 1);

        // Explicit steering, then an out-of-range select.
        step(1, 0, 2, 8'hA5, 1, 3'b111, 0);
        step(1, 0, 0, 8'h00, 0, 3'b111, 0);
        step(1, 0, 3, 8'h77, 1, 3'b111, 0);
        step(1, 0, 0, 8'h00, 0, 3'b111, 0);
        step(1, 0, 0, 8'h00, 0, 3'b111, 0);

        // Backpressure on channel 1, then drain and accept on the same edge.
        step(1, 0, 1, 8'h3C, 1, 3'b101, 0);
        repeat (5) step(1, 0, 0, 8'h99, 1, 3'b101, 0);
        step(1, 0, 0, 8'h42, 1, 3'b111, 0);
        step(1, 0, 0, 8'h00, 0, 3'b111, 0);

        // Round-robin burst: pointer wraps twice at the last channel.
        for (int i = 0; i < 6; i++) begin
            d = 8'h10 + 8'(i);
            step(1, 1, 3, d, 1, 3'b111, 0);
        end
        step(1, 1, 0, 8'h00, 0, 3'b111, 0);

        // Disable while holding: the beat drains, nothing new enters, pointer holds.
        step(1, 1, 0, 8'h55, 1, 3'b000, 0);
        step(0, 1, 0, 8'h66, 1, 3'b111, 0);
        step(0, 1, 0, 8'h67, 1, 3'b111, 0);
        step(1, 0, 0, 8'h00, 0, 3'b111, 0);

        // Reset while a beat is held discards it.
        step(1, 0, 2, 8'h81, 1, 3'b000, 0);
        step(1, 0, 0, 8'h00, 0, 3'b000, 1);
        step(1, 0, 0, 8'h00, 0, 3'b111, 0);

        // Random traffic, including out-of-range selects and disabled cycles.
        repeat (3000) begin
            step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                 SW'($urandom_range(0, 3)), DW'($urandom),
                 1'($urandom_range(0, 9) < 7), NCH'($urandom), 1'b0);
        end

        repeat (3) step(1, 0, 0, 8'h00, 0, 3'b111, 0);
        check("leftover_beats", 64'(exp_q.size()), 64'd0);
        check("leftover_errors", 64'(errq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
